rsa_host_responder: RTL and testbench

- FPGA-side responder for the ARM command/data protocol. It decodes 32-bit commands, receives 1024-bit operands into a fixed slot register file, and starts the RSA core. It returns the result through a valid/ready handshake and signals completion with a done/done_read handshake.
- Sits between the ARM interface and the exponentiation core, inside the RSA wrapper.

---
 rtl/rsa_host_responder.sv | 164 ++++++++++++++++
 tb/tb_rsa_host_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_responder.sv
`default_nettype none
// ============================================================================
// Module   : rsa_host_responder
// Brief    : ARM command/data responder; fills the operand slots, launches the
//            RSA core and returns its result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_host_responder #(
    parameter int W      = 1024,
    parameter int NSLOTS = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  arm_to_fpga_cmd,
    input  logic         arm_to_fpga_cmd_valid,
    output logic         fpga_to_arm_done,
    input  logic         fpga_to_arm_done_read,
    input  logic         arm_to_fpga_data_valid,
    output logic         arm_to_fpga_data_ready,
    input  logic [W-1:0] arm_to_fpga_data,
    output logic         fpga_to_arm_data_valid,
    input  logic         fpga_to_arm_data_ready,
    output logic [W-1:0] fpga_to_arm_data,
    output logic         core_start,
    output logic         core_decrypt,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic [W-1:0] op_msg,
    output logic [W-1:0] op_exp,
    output logic [W-1:0] op_n,
    output logic [W-1:0] op_rmodn,
    output logic [W-1:0] op_r2modn,
    output logic [3:0]   leds
);

    localparam int C_IDX_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_TX      = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_slot [NSLOTS];
    logic [C_IDX_W-1:0]   r_idx;
    logic [W-1:0]         r_result;
    logic                 r_data_ready;
    logic                 r_core_start;
    logic                 r_core_decrypt;
    logic                 r_have_result;
    logic                 w_done;
    logic                 w_tx_valid;
    logic                 w_cmd_read;
    logic                 w_cmd_core;
    logic                 w_cmd_write;
    logic                 w_rx_capture;
    logic                 w_core_accept;

    assign w_cmd_read    = (arm_to_fpga_cmd == 32'd0);
    assign w_cmd_core    = (arm_to_fpga_cmd == 32'd1) || (arm_to_fpga_cmd == 32'd3);
    assign w_cmd_write   = (arm_to_fpga_cmd == 32'd2);
    assign w_rx_capture  = (r_state == S_RX) && arm_to_fpga_data_valid;
    assign w_core_accept = (r_state == S_COMPUTE) && core_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_tx_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Unrecognised command words still complete so the host never stalls.
                if (arm_to_fpga_cmd_valid) begin
                    if (w_cmd_read)       w_next = S_RX;
                    else if (w_cmd_core)  w_next = S_START;
                    else if (w_cmd_write) w_next = S_TX;
                    else                  w_next = S_DONE;
                end
            end
            S_RX: begin
                if (arm_to_fpga_data_valid) w_next = S_DONE;
            end
            S_START: begin
                w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (core_done) w_next = S_DONE;
            end
            S_TX: begin
                w_tx_valid = 1'b1;
                if (fpga_to_arm_data_ready) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (fpga_to_arm_done_read) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_idx          <= '0;
            r_result       <= '0;
            r_data_ready   <= 1'b0;
            r_core_start   <= 1'b0;
            r_core_decrypt <= 1'b0;
            r_have_result  <= 1'b0;
        end else begin
            r_data_ready <= w_rx_capture;
            // Registered off START so the pulse lands two cycles after the command.
            r_core_start <= (r_state == S_START);
            if ((r_state == S_IDLE) && arm_to_fpga_cmd_valid && w_cmd_core) begin
                r_core_decrypt <= arm_to_fpga_cmd[1];
            end
            for (int i = 0; i < NSLOTS; i++) begin
                if (w_rx_capture && (r_idx == C_IDX_W'(i))) begin
                    r_slot[i] <= arm_to_fpga_data;
                end
            end
            if (r_state == S_START) begin
                r_idx <= '0;
            end else if (w_rx_capture) begin
                r_idx <= (r_idx == C_IDX_W'(NSLOTS - 1)) ? '0 : r_idx + 1'b1;
            end
            if (w_core_accept) begin
                r_result      <= core_result;
                r_have_result <= 1'b1;
            end
        end
    end

    assign fpga_to_arm_done       = w_done;
    assign fpga_to_arm_data_valid = w_tx_valid;
    assign fpga_to_arm_data       = r_result;
    assign arm_to_fpga_data_ready = r_data_ready;
    assign core_start             = r_core_start;
    assign core_decrypt           = r_core_decrypt;
    assign op_msg                 = r_slot[0];
    assign op_exp                 = r_slot[1];
    assign op_n                   = r_slot[2];
    assign op_rmodn               = r_slot[3];
    assign op_r2modn              = r_slot[4];
    assign leds                   = {r_have_result, r_state};

endmodule
`default_nettype wire

// File: tb/tb_rsa_host_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_host_responder
// Brief    : Directed scoreboard bench for rsa_host_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_host_responder;

    localparam int W        = 1024;
    localparam int NSLOTS   = 5;
    localparam int CORE_LAT = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  arm_to_fpga_cmd;
    logic         arm_to_fpga_cmd_valid;
    logic         fpga_to_arm_done;
    logic         fpga_to_arm_done_read;
    logic         arm_to_fpga_data_valid;
    logic         arm_to_fpga_data_ready;
    logic [W-1:0] arm_to_fpga_data;
    logic         fpga_to_arm_data_valid;
    logic         fpga_to_arm_data_ready;
    logic [W-1:0] fpga_to_arm_data;
    logic         core_start;
    logic         core_decrypt;
    logic         core_done;
    logic [W-1:0] core_result;
    logic [W-1:0] op_msg, op_exp, op_n, op_rmodn, op_r2modn;
    logic [3:0]   leds;

    always #5 clk = ~clk;

    rsa_host_responder #(.W(W), .NSLOTS(NSLOTS)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .core_start             (core_start),
        .core_decrypt           (core_decrypt),
        .core_done              (core_done),
        .core_result            (core_result),
        .op_msg                 (op_msg),
        .op_exp                 (op_exp),
        .op_n                   (op_n),
        .op_rmodn               (op_rmodn),
        .op_r2modn              (op_r2modn),
        .leds                   (leds)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] val;
    } rd_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] core_value;
    rd_t          q_rd[$];
    logic [W-1:0] q_tx[$];
    logic         q_start[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected DUT event at %0t", name, $time);
    endtask

    function automatic logic [W-1:0] slot_val(input int i);
        case (i)
            0:       return op_msg;
            1:       return op_exp;
            2:       return op_n;
            3:       return op_rmodn;
            4:       return op_r2modn;
            default: return '0;
        endcase
    endfunction

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin : monitor
        rd_t e;
        if (arm_to_fpga_data_ready) begin
            if (q_rd.size() == 0) fail_now("ready_pulse");
            else begin
                e = q_rd.pop_front();
                check($sformatf("slot%0d", e.idx), slot_val(e.idx), e.val);
            end
        end
        if (core_start) begin
            if (q_start.size() == 0) fail_now("core_start");
            else check("start_decrypt", {{(W-1){1'b0}}, core_decrypt}, {{(W-1){1'b0}}, q_start.pop_front()});
        end
        if (fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
            if (q_tx.size() == 0) fail_now("tx_handshake");
            else check("tx_data", fpga_to_arm_data, q_tx.pop_front());
        end
    end

    // Core model: answers each start with core_value after CORE_LAT cycles.
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                repeat (CORE_LAT) @(posedge clk);
                #1 core_done = 1'b1;
                core_result = core_value;
                @(posedge clk);
                #1 core_done = 1'b0;
                core_result = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        tick();
        arm_to_fpga_cmd       = c;
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = '0;
    endtask

    task automatic ack_done();
        tick();
        fpga_to_arm_done_read = 1'b1;
        @(negedge clk);
        check("done_held_at_ack", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        tick();
        fpga_to_arm_done_read = 1'b0;
        @(negedge clk);
        check("done_drop", {{(W-1){1'b0}}, fpga_to_arm_done}, 0);
    endtask

    task automatic read_op(input logic [W-1:0] val, input int idx);
        rd_t e;
        send_cmd(32'd0);
        e.idx = idx;
        e.val = val;
        q_rd.push_back(e);
        arm_to_fpga_data       = val;
        arm_to_fpga_data_valid = 1'b1;
        tick();
        arm_to_fpga_data_valid = 1'b0;
        @(negedge clk);
        check("rd_ready_pulse", {{(W-1){1'b0}}, arm_to_fpga_data_ready}, 1);
        check("rd_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        @(negedge clk);
        check("rd_ready_single", {{(W-1){1'b0}}, arm_to_fpga_data_ready}, 0);
        ack_done();
    endtask

    task automatic wait_core_done(input string name);
        int cyc;
        cyc = 0;
        while (!core_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!core_done) fail_now(name);
    endtask

    initial begin
        logic saw_done;
        reset                  = 1'b1;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_value             = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_op_msg", op_msg, 0);
        check("rst_op_exp", op_exp, 0);
        check("rst_op_n", op_n, 0);
        check("rst_op_rmodn", op_rmodn, 0);
        check("rst_op_r2modn", op_r2modn, 0);
        check("rst_data", fpga_to_arm_data, 0);
        check("rst_flags", {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                            core_start, core_decrypt}, 0);
        check("rst_leds", leds, 0);

        // Five reads fill slots in order, sixth wraps to slot 0
        for (int i = 0; i < 5; i++) read_op(W'((i + 1) * 'h11), i);
        check("op_msg", op_msg, 'h11);
        check("op_exp", op_exp, 'h22);
        check("op_n", op_n, 'h33);
        check("op_rmodn", op_rmodn, 'h44);
        check("op_r2modn", op_r2modn, 'h55);
        read_op('h66, 0);
        check("wrap_msg", op_msg, 'h66);
        check("wrap_exp", op_exp, 'h22);
        check("wrap_r2modn", op_r2modn, 'h55);

        // ENCRYPT: start pulse timing and done latency
        core_value = 'hABCD;
        q_start.push_back(1'b0);
        send_cmd(32'd1);
        @(negedge clk);
        check("enc_start_early", {{(W-1){1'b0}}, core_start}, 0);
        @(negedge clk);
        check("enc_start", {{(W-1){1'b0}}, core_start}, 1);
        @(negedge clk);
        check("enc_start_single", {{(W-1){1'b0}}, core_start}, 0);
        wait_core_done("enc_core_timeout");
        check("enc_done_before", {{(W-1){1'b0}}, fpga_to_arm_done}, 0);
        @(negedge clk);
        check("enc_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        check("enc_leds", leds, 4'hD);
        ack_done();

        // WRITE with ready already high: one-cycle valid
        fpga_to_arm_data_ready = 1'b1;
        q_tx.push_back('hABCD);
        send_cmd(32'd2);
        @(negedge clk);
        check("wr_valid", {{(W-1){1'b0}}, fpga_to_arm_data_valid}, 1);
        @(negedge clk);
        check("wr_valid_drop", {{(W-1){1'b0}}, fpga_to_arm_data_valid}, 0);
        check("wr_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        fpga_to_arm_data_ready = 1'b0;
        ack_done();

        // DECRYPT then READ restarts at slot 0
        core_value = 'h1234;
        q_start.push_back(1'b1);
        send_cmd(32'd3);
        wait_core_done("dec_core_timeout");
        check("dec_mode", {{(W-1){1'b0}}, core_decrypt}, 1);
        @(negedge clk);
        check("dec_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        ack_done();
        read_op('h77, 0);
        check("dec_idx_exp", op_exp, 'h22);

        // WRITE with ready stalled for 10 cycles
        q_tx.push_back('h1234);
        send_cmd(32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {{(W-1){1'b0}}, fpga_to_arm_data_valid}, 1);
            check("stall_data", fpga_to_arm_data, 'h1234);
        end
        tick();
        fpga_to_arm_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_valid_drop", {{(W-1){1'b0}}, fpga_to_arm_data_valid}, 0);
        check("stall_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        fpga_to_arm_data_ready = 1'b0;
        ack_done();

        // Unknown command completes with no side effects
        send_cmd(32'd5);
        @(negedge clk);
        check("bad_cmd_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        check("bad_cmd_state", leds, 4'hD);
        check("bad_cmd_msg", op_msg, 'h77);
        check("bad_cmd_n", op_n, 'h33);
        ack_done();

        // Commands during COMPUTE are dropped
        core_value = 'hBEEF;
        q_start.push_back(1'b0);
        send_cmd(32'd1);
        repeat (3) @(negedge clk);
        send_cmd(32'd0);
        @(negedge clk);
        check("busy_state", leds, 4'hB);
        wait_core_done("busy_core_timeout");
        @(negedge clk);
        check("busy_done", {{(W-1){1'b0}}, fpga_to_arm_done}, 1);
        check("busy_result", fpga_to_arm_data, 'hBEEF);
        ack_done();
        check("busy_idle", leds, 4'h8);

        // Reset in COMPUTE, then the late core_done must be ignored
        core_value = 'hDEAD;
        q_start.push_back(1'b1);
        send_cmd(32'd3);
        repeat (5) @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ops", op_msg | op_exp | op_n | op_rmodn | op_r2modn, 0);
        check("mid_rst_data", fpga_to_arm_data, 0);
        check("mid_rst_flags", {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                                core_start, core_decrypt}, 0);
        check("mid_rst_leds", leds, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fpga_to_arm_done || leds != 4'h0) saw_done = 1'b1;
        end
        check("late_core_done_ignored", {{(W-1){1'b0}}, saw_done}, 0);
        read_op('h99, 0);
        check("post_rst_exp", op_exp, 0);

        repeat (3) @(negedge clk);
        check("sb_rd_empty", q_rd.size(), 0);
        check("sb_tx_empty", q_tx.size(), 0);
        check("sb_start_empty", q_start.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
